// File: rtl/adc_spi_capture_if.sv
// Bus between the ADC clock/strobe source, the capture block and the sample consumer.
// The slave modport is the capture block's view; master is the view of the driving environment.
interface adc_spi_capture_if #(
  parameter int WIDTH = 16
) ();
  logic             sck;
  logic             cnv;
  logic             sdo;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             sample_ready;
  logic             overrun;
  logic             short_err;
  logic             clr_err;

  modport master (
    output sck, cnv, sdo, sample_ready, clr_err,
    input  sample, sample_valid, overrun, short_err
  );

  modport slave (
    input  sck, cnv, sdo, sample_ready, clr_err,
    output sample, sample_valid, overrun, short_err
  );
endinterface

// File: rtl/adc_spi_capture.sv
// Deserialises ADC serial data framed by cnv/sck into parallel samples held in a one-entry
// valid/ready register. Optional input synchroniser: define ADC_SPI_CAPTURE_SYNC_EN.
module adc_spi_capture #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  adc_spi_capture_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CNV = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_sck;
  logic             w_cnv;
  logic             w_sdo;
  logic             r_sckD;
  logic             r_cnvD;
  logic             w_sckRise;
  logic             w_cnvRise;
  logic             w_cnvFall;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_sample;
  logic             r_valid;
  logic             r_overrun;
  logic             r_shortErr;
  logic             w_clearFrame;
  logic             w_shiftEn;
  logic             w_load;
  logic             w_setOverrun;
  logic             w_setShort;

`ifdef ADC_SPI_CAPTURE_SYNC_EN
  // sck and cnv get the same two-flop delay as sdo so each bit is still sampled on its own sck rise.
  logic [1:0] r_sckPipe;
  logic [1:0] r_cnvPipe;
  logic [1:0] r_sdoPipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sckPipe <= '0;
      r_cnvPipe <= '0;
      r_sdoPipe <= '0;
    end else begin
      r_sckPipe <= {r_sckPipe[0], bus.sck};
      r_cnvPipe <= {r_cnvPipe[0], bus.cnv};
      r_sdoPipe <= {r_sdoPipe[0], bus.sdo};
    end
  end

  assign w_sck = r_sckPipe[1];
  assign w_cnv = r_cnvPipe[1];
  assign w_sdo = r_sdoPipe[1];
`else
  assign w_sck = bus.sck;
  assign w_cnv = bus.cnv;
  assign w_sdo = bus.sdo;
`endif

  assign w_sckRise = w_sck & ~r_sckD;
  assign w_cnvRise = w_cnv & ~r_cnvD;
  assign w_cnvFall = ~w_cnv & r_cnvD;

  always_comb begin
    w_nextState  = r_state;
    w_clearFrame = 1'b0;
    w_shiftEn    = 1'b0;
    w_load       = 1'b0;
    w_setOverrun = 1'b0;
    w_setShort   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cnvRise) w_nextState = WAIT_CNV;
      end
      WAIT_CNV: begin
        if (w_cnvFall) begin
          w_nextState  = SHIFT;
          w_clearFrame = 1'b1;
        end
      end
      SHIFT: begin
        // A full count takes priority so late sck pulses or cnv never corrupt a finished frame.
        if (r_count == CW'(WIDTH)) begin
          w_nextState = DONE;
        end else if (w_cnvRise) begin
          w_setShort  = 1'b1;
          w_nextState = WAIT_CNV;
        end else if (w_sckRise) begin
          w_shiftEn = 1'b1;
        end
      end
      DONE: begin
        if (!r_valid || bus.sample_ready) w_load = 1'b1;
        else w_setOverrun = 1'b1;
        w_nextState = w_cnvRise ? WAIT_CNV : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sckD  <= 1'b0;
      r_cnvD  <= 1'b0;
      r_count <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_nextState;
      r_sckD  <= w_sck;
      r_cnvD  <= w_cnv;
      if (w_clearFrame) begin
        r_count <= '0;
        r_shreg <= '0;
      end else if (w_shiftEn) begin
        r_shreg <= {r_shreg[WIDTH-2:0], w_sdo};
        r_count <= r_count + CW'(1);
      end
    end
  end

  // A load in the same cycle as a consume keeps valid high with the new sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else if (w_load) begin
      r_sample <= r_shreg;
      r_valid  <= 1'b1;
    end else if (r_valid && bus.sample_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun  <= 1'b0;
      r_shortErr <= 1'b0;
    end else begin
      if (w_setOverrun) r_overrun <= 1'b1;
      else if (bus.clr_err) r_overrun <= 1'b0;
      if (w_setShort) r_shortErr <= 1'b1;
      else if (bus.clr_err) r_shortErr <= 1'b0;
    end
  end

  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.overrun      = r_overrun;
  assign bus.short_err    = r_shortErr;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Self-checking bench for adc_spi_capture: frames are driven MSB first, expected samples are
// queued on a scoreboard and compared when the consumer handshake takes them.
module tb_adc_spi_capture;

  localparam int WIDTH = 16;
`ifdef ADC_SPI_CAPTURE_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] sbQueue[$];

  adc_spi_capture_if #(.WIDTH(WIDTH)) bus ();

  adc_spi_capture #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one frame: cnv pulse, then nbits sck pulses of one clk high / one clk low.
  task automatic applyStimulus(input logic [31:0] data, input int nbits, input bit expectSample);
    if (expectSample) sbQueue.push_back(data[WIDTH-1:0]);
    @(negedge clk) bus.cnv = 1'b1;
    @(negedge clk);
    @(negedge clk) bus.cnv = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.sdo = (i < WIDTH) ? data[WIDTH-1-i] : 1'($urandom_range(0, 1));
      bus.sck = 1'b1;
      @(negedge clk) bus.sck = 1'b0;
    end
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!bus.sample_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pulseReady();
    @(negedge clk) bus.sample_ready = 1'b1;
    @(negedge clk) bus.sample_ready = 1'b0;
  endtask

  task automatic pulseClr();
    @(negedge clk) bus.clr_err = 1'b1;
    @(negedge clk) bus.clr_err = 1'b0;
  endtask

  // Scoreboard: every accepted sample must match the oldest queued expectation.
  always @(negedge clk) begin
    #4;
    if (reset && bus.sample_valid && bus.sample_ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedValid", 32'(bus.sample_valid), 32'h0);
      end else begin
        checkOutput("sbSample", 32'(bus.sample), 32'(sbQueue.pop_front()));
      end
    end
  end

  initial begin
    int lat;
    reset            = 1'b0;
    bus.sck          = 1'b0;
    bus.cnv          = 1'b0;
    bus.sdo          = 1'b0;
    bus.sample_ready = 1'b0;
    bus.clr_err      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstSample", 32'(bus.sample), 32'h0);
    checkOutput("rstValid", 32'(bus.sample_valid), 32'h0);
    checkOutput("rstOverrun", 32'(bus.overrun), 32'h0);
    checkOutput("rstShort", 32'(bus.short_err), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] basic frame 0xA5C3");
    bus.sample_ready = 1'b1;
    applyStimulus(32'hA5C3, 16, 1'b1);
    waitValid(lat);
    checkOutput("latency1", 32'(lat), 32'(2 + SYNC_DLY));
    @(negedge clk);
    checkOutput("validOneCycle", 32'(bus.sample_valid), 32'h0);
    checkOutput("t1Overrun", 32'(bus.overrun), 32'h0);
    checkOutput("t1Short", 32'(bus.short_err), 32'h0);

    $display("[TB] overrun with ready low");
    bus.sample_ready = 1'b0;
    applyStimulus(32'h0001, 16, 1'b1);
    waitValid(lat);
    repeat (3) @(negedge clk);
    applyStimulus(32'hFFFF, 16, 1'b0);
    repeat (4 + SYNC_DLY) @(negedge clk);
    checkOutput("t2Overrun", 32'(bus.overrun), 32'h1);
    checkOutput("t2Held", 32'(bus.sample), 32'h0001);
    checkOutput("t2Valid", 32'(bus.sample_valid), 32'h1);
    pulseReady();
    checkOutput("t2Drained", 32'(bus.sample_valid), 32'h0);
    pulseClr();
    checkOutput("t2Cleared", 32'(bus.overrun), 32'h0);

    $display("[TB] short frame then 0x1234");
    bus.sample_ready = 1'b1;
    applyStimulus(32'hFFFF, 9, 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("t3NoValid", 32'(bus.sample_valid), 32'h0);
    checkOutput("t3ShortPre", 32'(bus.short_err), 32'h0);
    applyStimulus(32'h1234, 16, 1'b1);
    waitValid(lat);
    checkOutput("latency3", 32'(lat), 32'(2 + SYNC_DLY));
    @(negedge clk);
    checkOutput("t3Short", 32'(bus.short_err), 32'h1);
    pulseClr();
    checkOutput("t3ShortClr", 32'(bus.short_err), 32'h0);

    $display("[TB] consume coincident with load");
    bus.sample_ready = 1'b0;
    applyStimulus(32'h1111, 16, 1'b1);
    waitValid(lat);
    repeat (2) @(negedge clk);
    applyStimulus(32'h2222, 16, 1'b1);
    repeat (1 + SYNC_DLY) @(negedge clk);
    bus.sample_ready = 1'b1;
    @(negedge clk) bus.sample_ready = 1'b0;
    checkOutput("t4Valid", 32'(bus.sample_valid), 32'h1);
    checkOutput("t4Sample", 32'(bus.sample), 32'h2222);
    checkOutput("t4NoOverrun", 32'(bus.overrun), 32'h0);

    $display("[TB] clear coincident with overrun");
    applyStimulus(32'h3333, 16, 1'b0);
    repeat (1 + SYNC_DLY) @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk) bus.clr_err = 1'b0;
    checkOutput("t4SetWins", 32'(bus.overrun), 32'h1);
    checkOutput("t4Retained", 32'(bus.sample), 32'h2222);
    pulseClr();
    checkOutput("t4OvClr", 32'(bus.overrun), 32'h0);
    pulseReady();
    checkOutput("t4Drained", 32'(bus.sample_valid), 32'h0);

    $display("[TB] reset mid-frame");
    bus.sample_ready = 1'b1;
    applyStimulus(32'hFFFF, 8, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5Sample", 32'(bus.sample), 32'h0);
    checkOutput("t5Valid", 32'(bus.sample_valid), 32'h0);
    checkOutput("t5Overrun", 32'(bus.overrun), 32'h0);
    checkOutput("t5Short", 32'(bus.short_err), 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t5NoSpurious", 32'(bus.sample_valid), 32'h0);
    applyStimulus(32'h5A5A, 16, 1'b1);
    waitValid(lat);
    checkOutput("latency5", 32'(lat), 32'(2 + SYNC_DLY));
    @(negedge clk);
    checkOutput("t5ShortAfter", 32'(bus.short_err), 32'h0);

    $display("[TB] extra sck pulses");
    bus.sample_ready = 1'b0;
    applyStimulus(32'hC0DE, 20, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("t6Valid", 32'(bus.sample_valid), 32'h1);
    checkOutput("t6Sample", 32'(bus.sample), 32'hC0DE);
    checkOutput("t6Overrun", 32'(bus.overrun), 32'h0);
    pulseReady();

    repeat (5) @(negedge clk);
    checkOutput("sbEmpty", 32'(sbQueue.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
